// File: rtl/conf_word_rx_if.sv
// SPI-side inputs and configuration-word outputs of the framing stage.
// Master drives the SPI receiver signals and observes the word; slave is the framer.
// Pure wiring, no logic.
interface conf_word_rx_if;
    logic        i_spi_nCS;
    logic        i_spi_done;
    logic [7:0]  i_spi_byte;
    logic [63:0] o_conf;
    logic        o_conf_stb;
    logic        o_conf_valid;
    logic        o_err_crc;
    logic        o_err_frame;
    logic        o_busy;

    modport master (
        output i_spi_nCS, i_spi_done, i_spi_byte,
        input  o_conf, o_conf_stb, o_conf_valid, o_err_crc, o_err_frame, o_busy
    );

    modport slave (
        input  i_spi_nCS, i_spi_done, i_spi_byte,
        output o_conf, o_conf_stb, o_conf_valid, o_err_crc, o_err_frame, o_busy
    );
endinterface

// File: rtl/conf_word_rx.sv
// Assembles one checksummed 8-byte config word per chip-select frame from an async SPI byte receiver.
// Latency: byte captured 3 edges after done rises; word and strobe appear at most 5 edges after K's done rise.
// No backpressure: strobe is a one-cycle pulse; bytes outside a live frame window are dropped.
module conf_word_rx #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic           i_clk,
    input  logic           i_reset,
    conf_word_rx_if.slave  bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TMO_MAX  = {TW{1'b1}};
    localparam logic [7:0]    XOR_SEED = 8'hA5;

    typedef enum logic [1:0] {IDLE, RECV, CHECK, WAIT_CS} state_t;

    state_t        state;
    logic [2:0]    done_s;
    logic [2:0]    cs_s;
    logic [3:0]    idx;
    logic [63:0]   shreg;
    logic [7:0]    xr;
    logic [7:0]    k_byte;
    logic [TW-1:0] tmo;
    logic [63:0]   conf;
    logic          conf_stb;
    logic          conf_valid;
    logic          err_crc;
    logic          err_frame;
    logic          busy;
    logic          byte_ev;
    logic          cs_low;

    assign byte_ev = (done_s[2:1] == 2'b01);
    assign cs_low  = ~cs_s[2];

    assign bus.o_conf       = conf;
    assign bus.o_conf_stb   = conf_stb;
    assign bus.o_conf_valid = conf_valid;
    assign bus.o_err_crc    = err_crc;
    assign bus.o_err_frame  = err_frame;
    assign bus.o_busy       = busy;

    // Bring the async done flag and chip select into the i_clk domain.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            done_s <= 3'b000;
            cs_s   <= 3'b111;
        end else begin
            done_s <= {done_s[1:0], bus.i_spi_done};
            cs_s   <= {cs_s[1:0], bus.i_spi_nCS};
        end
    end

    // Frame FSM: collect B0..B7 and K, verify, publish the word, then wait out the chip select.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state      <= IDLE;
            idx        <= 4'd0;
            shreg      <= 64'h0;
            xr         <= XOR_SEED;
            k_byte     <= 8'h00;
            tmo        <= '0;
            conf       <= 64'h0;
            conf_stb   <= 1'b0;
            conf_valid <= 1'b0;
            err_crc    <= 1'b0;
            err_frame  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            conf_stb <= 1'b0;
            case (state)
                IDLE: begin
                    idx   <= 4'd0;
                    shreg <= 64'h0;
                    xr    <= XOR_SEED;
                    tmo   <= '0;
                    if (cs_low) begin
                        err_crc   <= 1'b0;
                        err_frame <= 1'b0;
                        busy      <= 1'b1;
                        state     <= RECV;
                    end
                end
                RECV: begin
                    if (byte_ev) begin
                        tmo <= '0;
                        if (idx < 4'd8) begin
                            shreg <= {shreg[55:0], bus.i_spi_byte};
                            xr    <= xr ^ bus.i_spi_byte;
                            idx   <= idx + 4'd1;
                            // A byte landing with the deassert is kept, but the frame is still short.
                            if (!cs_low) begin
                                err_frame <= 1'b1;
                                busy      <= 1'b0;
                                state     <= IDLE;
                            end
                        end else begin
                            k_byte <= bus.i_spi_byte;
                            state  <= CHECK;
                        end
                    end else if (!cs_low) begin
                        err_frame <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (tmo == TMO_LAST) begin
                        err_frame <= 1'b1;
                        busy      <= 1'b0;
                        state     <= WAIT_CS;
                    end else if (tmo != TMO_MAX) begin
                        tmo <= tmo + 1'b1;
                    end
                end
                CHECK: begin
                    if (k_byte == xr) begin
                        conf       <= shreg;
                        conf_stb   <= 1'b1;
                        conf_valid <= 1'b1;
                    end else begin
                        err_crc <= 1'b1;
                    end
                    busy  <= 1'b0;
                    state <= WAIT_CS;
                end
                WAIT_CS: begin
                    if (!cs_low) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_conf_word_rx.sv
// Scoreboard bench for conf_word_rx: stimulus pushes expected words, a monitor pops on each strobe.
// Uses a 100-cycle timeout so the slow-frame case stays short.
// Flag and hold checks are made from the stimulus process after each frame.
module tb_conf_word_rx;
    logic clk;
    logic rst;
    int   errors;
    int   checks;
    logic [63:0] sb[$];
    logic [7:0]  fb[$];
    logic [63:0] exp_conf;

    conf_word_rx_if bus();

    conf_word_rx #(.TIMEOUT_CYCLES(100)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cs_begin();
        bus.i_spi_nCS = 1'b0;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic cs_end();
        bus.i_spi_nCS = 1'b1;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.i_spi_byte = b;
        bus.i_spi_done = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        bus.i_spi_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic run_frame();
        cs_begin();
        for (int i = 0; i < fb.size(); i++) begin
            send_byte(fb[i]);
            if (i == 3 && fb.size() >= 9) chk("busy_mid_frame", {63'h0, bus.o_busy}, 64'h1);
        end
        cs_end();
    endtask

    // Monitor: every strobe must match the oldest outstanding expected word.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bus.o_conf_stb) begin
                checks = checks + 1;
                if (sb.size() == 0) begin
                    errors = errors + 1;
                    $display("FAIL unexpected_strobe: got conf %h, expected no strobe", bus.o_conf);
                end else begin
                    logic [63:0] e;
                    e = sb.pop_front();
                    if (bus.o_conf !== e) begin
                        errors = errors + 1;
                        $display("FAIL strobe_word: got %h, expected %h", bus.o_conf, e);
                    end
                end
            end
        end
    end

    initial begin
        errors = 0;
        checks = 0;
        exp_conf = 64'h0;
        rst = 1'b1;
        bus.i_spi_nCS  = 1'b1;
        bus.i_spi_done = 1'b0;
        bus.i_spi_byte = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_conf",      bus.o_conf, 64'h0);
        chk("rst_stb",       {63'h0, bus.o_conf_stb}, 64'h0);
        chk("rst_valid",     {63'h0, bus.o_conf_valid}, 64'h0);
        chk("rst_err_crc",   {63'h0, bus.o_err_crc}, 64'h0);
        chk("rst_err_frame", {63'h0, bus.o_err_frame}, 64'h0);
        chk("rst_busy",      {63'h0, bus.o_busy}, 64'h0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Bad checksum straight after reset: word must stay 0.
        fb = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h00};
        run_frame();
        chk("crc_err_set",   {63'h0, bus.o_err_crc}, 64'h1);
        chk("crc_frame_ok",  {63'h0, bus.o_err_frame}, 64'h0);
        chk("crc_conf_hold", bus.o_conf, exp_conf);
        chk("crc_valid_lo",  {63'h0, bus.o_conf_valid}, 64'h0);

        // Good frame 01..08, K = 0x08 ^ 0xA5 = 0xAD.
        exp_conf = 64'h0102030405060708;
        sb.push_back(exp_conf);
        fb = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'hAD};
        run_frame();
        chk("good1_strobe_seen", 64'(sb.size()), 64'h0);
        chk("good1_conf",      bus.o_conf, exp_conf);
        chk("good1_valid",     {63'h0, bus.o_conf_valid}, 64'h1);
        chk("good1_err_crc",   {63'h0, bus.o_err_crc}, 64'h0);
        chk("good1_err_frame", {63'h0, bus.o_err_frame}, 64'h0);
        chk("good1_busy",      {63'h0, bus.o_busy}, 64'h0);

        // All-ones frame plus three trailing bytes that must be dropped.
        exp_conf = 64'hFFFF_FFFF_FFFF_FFFF;
        sb.push_back(exp_conf);
        fb = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hA5, 8'h12, 8'h34, 8'h56};
        run_frame();
        chk("ff_strobe_seen", 64'(sb.size()), 64'h0);
        chk("ff_conf",        bus.o_conf, exp_conf);

        // Short frame: four bytes then chip select released.
        fb = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_frame();
        chk("short_err_frame", {63'h0, bus.o_err_frame}, 64'h1);
        chk("short_conf_hold", bus.o_conf, exp_conf);
        chk("short_busy",      {63'h0, bus.o_busy}, 64'h0);

        // Next good frame clears the frame error; K = 0x80 ^ 0xA5 = 0x25.
        exp_conf = 64'h1020304050607080;
        sb.push_back(exp_conf);
        fb = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80, 8'h25};
        run_frame();
        chk("good2_strobe_seen", 64'(sb.size()), 64'h0);
        chk("good2_conf",      bus.o_conf, exp_conf);
        chk("good2_err_frame", {63'h0, bus.o_err_frame}, 64'h0);

        // Slow frame: three bytes then a gap past the timeout; later bytes ignored.
        cs_begin();
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        repeat (110) @(posedge clk);
        #1;
        chk("tmo_err_frame", {63'h0, bus.o_err_frame}, 64'h1);
        chk("tmo_busy",      {63'h0, bus.o_busy}, 64'h0);
        send_byte(8'h44);
        send_byte(8'h55);
        send_byte(8'h66);
        send_byte(8'h77);
        send_byte(8'h88);
        send_byte(8'hE2);
        cs_end();
        chk("tmo_conf_hold",  bus.o_conf, exp_conf);
        chk("tmo_err_sticky", {63'h0, bus.o_err_frame}, 64'h1);
        chk("tmo_err_crc",    {63'h0, bus.o_err_crc}, 64'h0);

        // Reset in the middle of a frame returns every output to its reset value at once.
        cs_begin();
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        send_byte(8'hDD);
        send_byte(8'hEE);
        rst = 1'b1;
        #1;
        exp_conf = 64'h0;
        chk("mid_rst_conf",  bus.o_conf, exp_conf);
        chk("mid_rst_valid", {63'h0, bus.o_conf_valid}, 64'h0);
        chk("mid_rst_err",   {62'h0, bus.o_err_crc, bus.o_err_frame}, 64'h0);
        chk("mid_rst_busy",  {63'h0, bus.o_busy}, 64'h0);
        bus.i_spi_nCS = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Fresh frame after reset; K = 0x22 ^ 0xA5 = 0x87.
        exp_conf = 64'hDEADBEEF00112233;
        sb.push_back(exp_conf);
        fb = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h11, 8'h22, 8'h33, 8'h87};
        run_frame();
        chk("post_rst_strobe_seen", 64'(sb.size()), 64'h0);
        chk("post_rst_conf",  bus.o_conf, exp_conf);
        chk("post_rst_valid", {63'h0, bus.o_conf_valid}, 64'h1);

        repeat (5) @(posedge clk);
        #1;
        chk("sb_drained", 64'(sb.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
